// File: rtl/ring_pkg.sv
// Shared types, default sizes and the expected-code rotate for the ring tracker stages.
package ring_pkg;

    typedef enum logic [1:0] {SEEK, LOCK, RECOVER} state_e;

    localparam int unsigned RING_WIDTH = 4;
    localparam int unsigned RING_REV_W = 8;

    // Rotate-left by one inside a ring of 'width' bits (width <= 32); bits above width stay 0.
    function automatic logic [31:0] rotl1(input logic [31:0] code, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return ((code << 1) | (code >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot legality check plus binary encode of the hot bit position.
module onehot_enc
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = RING_WIDTH
) (
    input  logic [WIDTH-1:0]         code_i,
    output logic                     legal_o,
    output logic [$clog2(WIDTH)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    int unsigned hot_cnt;

    // OR-ing the indices is exact when exactly one bit is set; other cases are flagged illegal.
    always_comb begin
        hot_cnt = 0;
        idx_o   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code_i[i]) begin
                hot_cnt = hot_cnt + 1;
                idx_o   = idx_o | IDX_W'(i);
            end
        end
        legal_o = (hot_cnt == 1);
    end

endmodule

// File: rtl/ring_phase_tracker.sv
// Tracks a one-hot ring counter: phase index, revolution count, sequence errors and preset recovery.
// Define RING_TRACK_ERRCNT_EN to build the saturating error counter behind err_cnt.
module ring_phase_tracker
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH       = RING_WIDTH,
    parameter int unsigned REV_W       = RING_REV_W,
    parameter int unsigned FAULT_LIMIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     ring_vld,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_vld,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     rev_pulse,
    output logic                     err_seq,
    output logic                     fault,
    output logic                     preset_req,
    output logic [7:0]               err_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned ILL_W = $clog2(FAULT_LIMIT + 1);

    state_e             state_q, state_d;
    logic [ILL_W-1:0]   ill_q, ill_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic [REV_W-1:0]   rev_q, rev_d;
    logic               rev_pulse_q, rev_pulse_d;
    logic               err_seq_q, err_seq_d;

    logic               legal;
    logic [IDX_W-1:0]   enc_idx;
    logic [31:0]        exp_code;
    logic               seq_ok;

    onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .code_i  (ring_in),
        .legal_o (legal),
        .idx_o   (enc_idx)
    );

    assign exp_code = rotl1(32'(prev_q), WIDTH);
    assign seq_ok   = (exp_code == 32'(ring_in));

    always_comb begin
        state_d     = state_q;
        ill_d       = ill_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        rev_d       = rev_q;
        rev_pulse_d = 1'b0;
        err_seq_d   = 1'b0;
        if (ring_vld) begin
            prev_d = ring_in;
            unique case (state_q)
                SEEK: begin
                    if (legal) begin
                        state_d = LOCK;
                        idx_d   = enc_idx;
                        vld_d   = 1'b1;
                        ill_d   = '0;
                    end else begin
                        ill_d = ill_q + ILL_W'(1);
                        if (32'(ill_q) + 32'd1 >= FAULT_LIMIT) state_d = RECOVER;
                    end
                end
                LOCK: begin
                    if (legal) begin
                        idx_d = enc_idx;
                        if (seq_ok) begin
                            if (prev_q[WIDTH-1] && ring_in[0]) begin
                                rev_d       = rev_q + REV_W'(1);
                                rev_pulse_d = 1'b1;
                            end
                        end else begin
                            err_seq_d = 1'b1;
                        end
                    end else begin
                        vld_d   = 1'b0;
                        ill_d   = ILL_W'(1);
                        state_d = (FAULT_LIMIT == 1) ? RECOVER : SEEK;
                    end
                end
                RECOVER: begin
                    // Only a ring restarted at phase 0 ends recovery.
                    if (ring_in == WIDTH'(1)) begin
                        state_d = LOCK;
                        idx_d   = '0;
                        vld_d   = 1'b1;
                        ill_d   = '0;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEEK;
            ill_q       <= '0;
            prev_q      <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
            rev_q       <= '0;
            rev_pulse_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ill_q       <= ill_d;
            prev_q      <= prev_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
            rev_q       <= rev_d;
            rev_pulse_q <= rev_pulse_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign phase_idx  = idx_q;
    assign phase_vld  = vld_q;
    assign rev_cnt    = rev_q;
    assign rev_pulse  = rev_pulse_q;
    assign err_seq    = err_seq_q;
    assign fault      = (state_q == RECOVER);
    assign preset_req = (state_q == RECOVER);

`ifdef RING_TRACK_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ring_vld && (!legal || err_seq_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_phase_tracker.sv
// Self-checking bench for ring_phase_tracker: directed table, corner sequences, randomized model check.
module tb_ring_phase_tracker;

    localparam int W  = 4;
    localparam int FL = 2;

    logic       clk;
    logic       rst;
    logic [3:0] ring_in;
    logic       ring_vld;
    logic [1:0] phase_idx;
    logic       phase_vld;
    logic [7:0] rev_cnt;
    logic       rev_pulse;
    logic       err_seq;
    logic       fault;
    logic       preset_req;
    logic [7:0] err_cnt;

    ring_phase_tracker #(.WIDTH(W), .REV_W(8), .FAULT_LIMIT(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .ring_in    (ring_in),
        .ring_vld   (ring_vld),
        .phase_idx  (phase_idx),
        .phase_vld  (phase_vld),
        .rev_cnt    (rev_cnt),
        .rev_pulse  (rev_pulse),
        .err_seq    (err_seq),
        .fault      (fault),
        .preset_req (preset_req),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 = seeking, 1 = locked, 2 = recovering.
    int m_mode, m_idx, m_vld, m_rev, m_rp, m_es, m_ill, m_err;

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] ring;
        int         idx;
        int         pv;
        int         rev;
        int         rp;
        int         es;
        int         flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic [3:0] ring, int idx, int pv, int rev,
                                int rp, int es, int flt);
        vec_t t;
        t.r = r; t.v = v; t.ring = ring; t.idx = idx; t.pv = pv; t.rev = rev;
        t.rp = rp; t.es = es; t.flt = flt;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] ring);
        int ones, pos;
        bit illegal;
        if (r) begin
            m_mode = 0; m_idx = 0; m_vld = 0; m_rev = 0; m_rp = 0; m_es = 0; m_ill = 0;
            m_err = 0;
            return;
        end
        m_rp = 0;
        m_es = 0;
        if (!v) return;
        ones = $countones(ring);
        pos = 0;
        for (int i = 0; i < W; i++) if (ring[i]) pos = i;
        illegal = (ones != 1);
        case (m_mode)
            0: begin
                if (!illegal) begin
                    m_mode = 1; m_idx = pos; m_vld = 1; m_ill = 0;
                end else begin
                    m_ill++;
                    if (m_ill >= FL) m_mode = 2;
                end
            end
            1: begin
                if (!illegal) begin
                    if (pos == (m_idx + 1) % W) begin
                        if (pos == 0) begin
                            m_rev = (m_rev + 1) % 256;
                            m_rp  = 1;
                        end
                    end else begin
                        m_es = 1;
                    end
                    m_idx = pos;
                end else begin
                    m_vld = 0;
                    m_ill = 1;
                    m_mode = (FL == 1) ? 2 : 0;
                end
            end
            default: begin
                if (ring == 4'b0001) begin
                    m_mode = 1; m_idx = 0; m_vld = 1; m_ill = 0;
                end
            end
        endcase
`ifdef RING_TRACK_ERRCNT_EN
        if ((illegal || m_es == 1) && m_err < 255) m_err++;
`endif
    endtask

    task automatic apply(input logic r, input logic v, input logic [3:0] ring);
        rst = r;
        ring_vld = v;
        ring_in = ring;
        model_step(r, v, ring);
        @(posedge clk);
        #1;
        chk("m_phase_idx", int'(phase_idx), m_idx);
        chk("m_phase_vld", int'(phase_vld), m_vld);
        chk("m_rev_cnt", int'(rev_cnt), m_rev);
        chk("m_rev_pulse", int'(rev_pulse), m_rp);
        chk("m_err_seq", int'(err_seq), m_es);
        chk("m_fault", int'(fault), (m_mode == 2) ? 1 : 0);
        chk("m_preset_req", int'(preset_req), (m_mode == 2) ? 1 : 0);
        chk("m_err_cnt", int'(err_cnt), m_err);
    endtask

    initial begin
        int pos;
        int rr;
        logic [3:0] stim;
        rst = 1'b1;
        ring_vld = 1'b0;
        ring_in = 4'b0000;
        m_mode = 0; m_idx = 0; m_vld = 0; m_rev = 0; m_rp = 0; m_es = 0; m_ill = 0; m_err = 0;

        //           r     v     ring     idx pv rev rp es flt
        tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 3, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0110, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0110, 0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0110, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b1000, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0101, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 1, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0100, 2, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 3, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0001, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0011, 0, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 0, 0, 3, 0, 0, 1));
        tbl.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0010, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].ring);
            chk($sformatf("t%0d_phase_idx", i), int'(phase_idx), tbl[i].idx);
            chk($sformatf("t%0d_phase_vld", i), int'(phase_vld), tbl[i].pv);
            chk($sformatf("t%0d_rev_cnt", i), int'(rev_cnt), tbl[i].rev);
            chk($sformatf("t%0d_rev_pulse", i), int'(rev_pulse), tbl[i].rp);
            chk($sformatf("t%0d_err_seq", i), int'(err_seq), tbl[i].es);
            chk($sformatf("t%0d_fault", i), int'(fault), tbl[i].flt);
            chk($sformatf("t%0d_preset_req", i), int'(preset_req), tbl[i].flt);
        end

        // Reverse step and hold are both legal-but-unexpected codes.
        apply(1'b0, 1'b1, 4'b0100);
        apply(1'b0, 1'b1, 4'b0010);
        chk("reverse_err_seq", int'(err_seq), 1);
        chk("reverse_idx", int'(phase_idx), 1);
        apply(1'b0, 1'b1, 4'b0010);
        chk("hold_err_seq", int'(err_seq), 1);

        // 300 illegal samples drive the error counter into saturation.
        apply(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 300; i++) apply(1'b0, 1'b1, 4'b0110);
`ifdef RING_TRACK_ERRCNT_EN
        chk("errcnt_saturate", int'(err_cnt), 255);
`else
        chk("errcnt_tied_zero", int'(err_cnt), 0);
`endif
        chk("sat_fault", int'(fault), 1);

        // Randomized run against the model.
        apply(1'b1, 1'b0, 4'b0000);
        pos = 3;
        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 99);
            if (rr < 70) begin
                pos  = (pos + 1) % W;
                stim = 4'(1 << pos);
            end else if (rr < 80) begin
                stim = 4'(1 << $urandom_range(0, W - 1));
            end else if (rr < 95) begin
                stim = 4'($urandom_range(0, 15));
            end else begin
                pos  = 0;
                stim = 4'b0001;
            end
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), stim);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_phase_tracker.md
Name: ring_phase_tracker

Overview:
- Downstream consumer of the 4-bit one-hot synchronous ring counter.
- Samples the ring state, checks it is a legal one-hot code advancing in rotate-left order, and emits a binary phase index plus a revolution count.
- Detects skipped or illegal codes. On persistent corruption it drives the ring counter's preset input until the ring restarts at phase 0.

Parameters:
- WIDTH, 4, ring length in bits (≥2).
- REV_W, 8, revolution counter width.
- FAULT_LIMIT, 2, consecutive illegal samples that trigger recovery (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ring_in  in  WIDTH  ring counter state (Q).
- ring_vld  in  1  ring_in is valid and the ring advanced this cycle; sample only when high.
- phase_idx  out  $clog2(WIDTH)  binary index of the hot bit.
- phase_vld  out  1  phase_idx is trustworthy.
- rev_cnt  out  REV_W  completed revolutions, wraps modulo 2^REV_W.
- rev_pulse  out  1  one-cycle pulse per completed revolution.
- err_seq  out  1  one-cycle pulse: a legal code was not the expected next phase.
- fault  out  1  high while in RECOVER.
- preset_req  out  1  drives the ring counter's preset input.
- err_cnt  out  8  error count (see Optional Feature).

Behaviour:
- Reset: all outputs are 0. State = SEEK; illegal-count = 0; stored previous sample = 0.
  - rst has priority over every other event, including mid-recovery.
- Outputs are registered and update on the clk edge that samples ring_vld=1, so they are visible 1 cycle after the sample.
- ring_vld=0: state and all outputs hold, except pulses (rev_pulse, err_seq), which return to 0.
- Legal means exactly one bit set. Expected next code = rotate-left of the previous sample; bit WIDTH-1 wraps to bit 0.
- SEEK:
  - Legal sample: go to LOCK; phase_idx = encode(sample); phase_vld=1; illegal-count=0; no rev_pulse, no err_seq.
  - Illegal sample: illegal-count++. When it reaches FAULT_LIMIT, go to RECOVER.
- LOCK:
  - Sample == expected: update phase_idx. If previous bit WIDTH-1 was set and new bit 0 is set, rev_cnt++ and rev_pulse=1.
  - Legal but not expected (skip, hold, or reverse): err_seq=1; resync phase_idx to the sample; no rev increment.
  - Illegal: phase_vld=0; illegal-count=1 (or go to RECOVER if FAULT_LIMIT=1); go to SEEK.
- RECOVER:
  - preset_req=1, fault=1, phase_vld=0.
  - Sampled ring_in == 1 (bit 0 only): next cycle preset_req=0, fault=0, state=LOCK, phase_idx=0, phase_vld=1, illegal-count=0. No rev_pulse.
  - Any other sample: stay in RECOVER. No timeout.
- rev_cnt survives SEEK/RECOVER; it is cleared only by rst.

Optional Feature:
- Macro: RING_TRACK_ERRCNT_EN.
- Defined: err_cnt is an 8-bit saturating counter (holds at 255).
  - Increments once per err_seq pulse and once per illegal sample.
  - Cleared only by rst.
- Undefined: err_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package ring_pkg holds:
  - typedef of the state enum {SEEK, LOCK, RECOVER};
  - default constants RING_WIDTH=4, RING_REV_W=8;
  - function rotl1 for the expected-code rotate.
- One sub-module, onehot_enc: combinational legal-check plus binary encode of ring_in, reusable by other ring stages.

Test Plan (WIDTH=4, FAULT_LIMIT=2, ring_vld=1 unless stated):
- Reset then ring_in 0001,0010,0100,1000,0001 → phase_idx 0,1,2,3,0; phase_vld=1 from the first sample; rev_pulse on the 5th sample only; rev_cnt=1; err_seq never asserted.
- In LOCK at 0010, drive 1000 → err_seq pulse; phase_idx=3. Then 0001 → rev_pulse; rev_cnt increments.
- Drive 0110 twice → phase_vld=0 after the first; fault=1 and preset_req=1 after the second. Then drive 0001 → preset_req/fault drop; phase_idx=0; phase_vld=1.
- ring_vld=0 for 5 cycles with ring_in toggling garbage → all outputs unchanged, no pulses.
- Assert rst during RECOVER → next cycle all outputs 0, state SEEK.
- RING_TRACK_ERRCNT_EN defined, 300 illegal samples → err_cnt saturates at 255. Undefined → err_cnt stays 0.
